// File: rtl/sobel_pkg.sv
// Shared encodings and helpers for the row-streaming Sobel filter.
package sobel_pkg;

    localparam logic [1:0] MODE_SUM  = 2'd0;
    localparam logic [1:0] MODE_GX   = 2'd1;
    localparam logic [1:0] MODE_GY   = 2'd2;
    localparam logic [1:0] MODE_PASS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HAVE1 = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } sobel_state_e;

    // LSB position of (column, channel) inside a packed row; column 0 sits at the LSBs.
    function automatic int pix_lsb(input int col, input int ch, input int channels, input int pix_w);
        return (col * channels + ch) * pix_w;
    endfunction

    function automatic logic [31:0] saturate(input logic [31:0] val, input int pix_w);
        logic [31:0] max_val;
        max_val = (32'd1 << pix_w) - 32'd1;
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/sobel_kernel_3x3.sv
// One 3x3 Sobel tap set for a single channel sample; purely combinational.
module sobel_kernel_3x3
    import sobel_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] p11,
    input  logic [PIX_W-1:0] p12,
    input  logic [PIX_W-1:0] p13,
    input  logic [PIX_W-1:0] p21,
    input  logic [PIX_W-1:0] p22,
    input  logic [PIX_W-1:0] p23,
    input  logic [PIX_W-1:0] p31,
    input  logic [PIX_W-1:0] p32,
    input  logic [PIX_W-1:0] p33,
    output logic [PIX_W-1:0] pix_out
);

    localparam int W = PIX_W + 4;

    logic [W-1:0]        left_sum;
    logic [W-1:0]        right_sum;
    logic [W-1:0]        top_sum;
    logic [W-1:0]        bot_sum;
    logic signed [W-1:0] gx;
    logic signed [W-1:0] gy;
    logic [W-1:0]        abs_gx;
    logic [W-1:0]        abs_gy;
    logic [W-1:0]        mag;

    assign left_sum  = W'(p11) + (W'(p21) << 1) + W'(p31);
    assign right_sum = W'(p13) + (W'(p23) << 1) + W'(p33);
    assign top_sum   = W'(p11) + (W'(p12) << 1) + W'(p13);
    assign bot_sum   = W'(p31) + (W'(p32) << 1) + W'(p33);

    // Modular subtraction at W bits yields the correct two's-complement gradient.
    assign gx = right_sum - left_sum;
    assign gy = top_sum - bot_sum;

    assign abs_gx = gx[W-1] ? W'(-gx) : W'(gx);
    assign abs_gy = gy[W-1] ? W'(-gy) : W'(gy);

    always_comb begin
        mag = abs_gx + abs_gy;
        case (mode)
            MODE_GX: mag = abs_gx;
            MODE_GY: mag = abs_gy;
            default: mag = abs_gx + abs_gy;
        endcase
    end

    assign pix_out = (mode == MODE_PASS) ? p22 : PIX_W'(saturate(32'(mag), PIX_W));

endmodule

// File: rtl/sobel_row_stream.sv
// Row-streaming 3x3 Sobel filter: one row in per handshake, one filtered row out, plus a flush row per frame.
//  state    | meaning
//  IDLE     | waiting for row 0 of a frame; latches mode
//  HAVE1    | row 0 held; next accepted row emits output row 0
//  RUN      | each accepted row k emits output row k-1
//  FLUSH    | all rows in; emit last output row with frame_done
module sobel_row_stream
    import sobel_pkg::*;
#(
    parameter int COLS     = 256,
    parameter int ROWS     = 256,
    parameter int PIX_W    = 8,
    parameter int CHANNELS = 3
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [1:0]                      mode,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [COLS*CHANNELS*PIX_W-1:0]  row_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [COLS*CHANNELS*PIX_W-1:0]  row_out,
    output logic                            frame_done
);

    localparam int ROW_W = COLS * CHANNELS * PIX_W;
    localparam int CNT_W = $clog2(ROWS);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    sobel_state_e     state_q;
    sobel_state_e     state_d;
    logic [CNT_W-1:0] row_cnt_q;
    logic [1:0]       mode_q;
    logic [ROW_W-1:0] line_a;
    logic [ROW_W-1:0] line_b;
    logic [ROW_W-1:0] win_bot;
    logic [ROW_W-1:0] kern_row;
    logic             slot_free;
    logic             accept;
    logic             emit;
    logic             emit_last;

    assign slot_free = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // line_a/line_b are the two rows above the incoming one; in FLUSH the bottom row replicates line_b.
    assign win_bot = (state_q == ST_FLUSH) ? line_b : row_in;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        emit      = 1'b0;
        emit_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_HAVE1;
            end
            ST_HAVE1: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    emit    = 1'b1;
                    state_d = (ROWS == 2) ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    emit = 1'b1;
                    if (row_cnt_q + CNT_W'(1) == LAST_ROW) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    emit      = 1'b1;
                    emit_last = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            row_cnt_q  <= '0;
            mode_q     <= MODE_SUM;
            line_a     <= '0;
            line_b     <= '0;
            row_out    <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                line_a <= (state_q == ST_IDLE) ? row_in : line_b;
                line_b <= row_in;
                if (state_q == ST_IDLE) begin
                    mode_q    <= mode;
                    row_cnt_q <= '0;
                end else begin
                    row_cnt_q <= row_cnt_q + CNT_W'(1);
                end
            end else if (emit_last) begin
                row_cnt_q <= '0;
            end

            if (emit) begin
                row_out   <= kern_row;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            frame_done <= emit_last;
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int CL = (c == 0) ? 0 : c - 1;
        localparam int CR = (c == COLS - 1) ? COLS - 1 : c + 1;
        for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
            localparam int LL = pix_lsb(CL, ch, CHANNELS, PIX_W);
            localparam int LM = pix_lsb(c,  ch, CHANNELS, PIX_W);
            localparam int LR = pix_lsb(CR, ch, CHANNELS, PIX_W);

            sobel_kernel_3x3 #(
                .PIX_W (PIX_W)
            ) u_kernel (
                .mode    (mode_q),
                .p11     (line_a[LL +: PIX_W]),
                .p12     (line_a[LM +: PIX_W]),
                .p13     (line_a[LR +: PIX_W]),
                .p21     (line_b[LL +: PIX_W]),
                .p22     (line_b[LM +: PIX_W]),
                .p23     (line_b[LR +: PIX_W]),
                .p31     (win_bot[LL +: PIX_W]),
                .p32     (win_bot[LM +: PIX_W]),
                .p33     (win_bot[LR +: PIX_W]),
                .pix_out (kern_row[LM +: PIX_W])
            );
        end
    end

endmodule
